key_scan: RTL and testbench



---
 rtl/key_pkg.sv | 27 ++
 rtl/key_col_sync.sv | 30 +++
 rtl/key_scan.sv | 222 ++++++++++++++++++++++
 tb/tb_key_scan.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/key_pkg.sv
// Shared types and constants for the keypad front end: FSM states, key-code
// table, frame-result encoding and the enter code.
package key_pkg;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_DEBOUNCE = 2'd1,
        ST_HELD     = 2'd2,
        ST_RELEASE  = 2'd3
    } key_state_e;

    localparam logic [1:0] FRAME_NONE   = 2'd0;
    localparam logic [1:0] FRAME_SINGLE = 2'd1;
    localparam logic [1:0] FRAME_MULTI  = 2'd2;

    localparam logic [3:0] KEY_ENTER = 4'hF;

    // Nibble {row,col} holds the code; r0c0 sits in the least significant nibble.
    localparam logic [63:0] KEY_TABLE = 64'hDF0E_C987_B654_A321;

    function automatic logic [3:0] key_code(input logic [1:0] row, input logic [1:0] col);
        int idx;
        idx = int'({row, col});
        return KEY_TABLE[idx*4 +: 4];
    endfunction

endpackage

// File: rtl/key_col_sync.sv
// Two-flop synchroniser for the asynchronous keypad column lines; resets to
// all-released (4'hF).
module key_col_sync (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] col_async,
    output logic [3:0] col_sync
);

    logic [3:0] meta_q, meta_d;
    logic [3:0] sync_q, sync_d;

    always_comb begin
        meta_d = col_async;
        sync_d = meta_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            meta_q <= 4'hF;
            sync_q <= 4'hF;
        end else begin
            meta_q <= meta_d;
            sync_q <= sync_d;
        end
    end

    assign col_sync = sync_q;

endmodule

// File: rtl/key_scan.sv
// 4x4 active-low keypad scanner with frame-based debounce and one-cycle accept
// strobe. Auto-repeat of a held key is built only when KEY_REPEAT_EN is defined.
module key_scan
    import key_pkg::*;
#(
    parameter int SCAN_DIV            = 5000,
    parameter int DEBOUNCE_FRAMES     = 50,
    parameter int REPEAT_DELAY_FRAMES = 1250,
    parameter int REPEAT_RATE_FRAMES  = 250
) (
    input  logic       IN_clk,
    input  logic       IN_reset,
    input  logic [3:0] IN_col,
    output logic [3:0] OUT_row,
    output logic [3:0] OUT_value,
    output logic       OUT_key,
    output key_state_e OUT_state
);

    localparam int SLOT_W = $clog2(SCAN_DIV);
    localparam int CNT_W  = $clog2(DEBOUNCE_FRAMES + 1);
    localparam logic [SLOT_W-1:0] SLOT_LAST  = SLOT_W'(SCAN_DIV - 1);
    localparam logic [CNT_W-1:0]  CNT_ONE    = CNT_W'(1);
    localparam logic [CNT_W-1:0]  CNT_MAX    = '1;
    localparam logic [CNT_W-1:0]  DEB_TARGET = CNT_W'(DEBOUNCE_FRAMES);

    logic [SLOT_W-1:0] slot_q, slot_d;
    logic [1:0]        row_q, row_d;
    logic              acc_hit_q, acc_hit_d;
    logic              acc_multi_q, acc_multi_d;
    logic [3:0]        acc_code_q, acc_code_d;
    key_state_e        state_q, state_d;
    logic [3:0]        cand_q, cand_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d, cnt_inc;
    logic [3:0]        value_q, value_d;
    logic              key_q, key_d;

    logic [3:0] col_sync, col_low;
    logic [1:0] col_idx, frame_res;
    logic       slot_end, frame_end, row_single, row_multi;
    logic       hit_now, multi_now, accept;
    logic [3:0] code_now;

`ifdef KEY_REPEAT_EN
    localparam int REP_MAX = (REPEAT_DELAY_FRAMES > REPEAT_RATE_FRAMES) ?
                             REPEAT_DELAY_FRAMES : REPEAT_RATE_FRAMES;
    localparam int REP_W   = $clog2(REP_MAX + 1);
    localparam logic [REP_W-1:0] REP_DELAY = REP_W'(REPEAT_DELAY_FRAMES);
    localparam logic [REP_W-1:0] REP_RATE  = REP_W'(REPEAT_RATE_FRAMES);
    logic [REP_W-1:0] rep_cnt_q, rep_cnt_d, rep_inc;
    logic             rep_started_q, rep_started_d;
`endif

    key_col_sync u_col_sync (
        .clk       (IN_clk),
        .reset     (IN_reset),
        .col_async (IN_col),
        .col_sync  (col_sync)
    );

    // Row scan plus per-frame accumulation of the sampled columns.
    always_comb begin
        slot_end  = (slot_q == SLOT_LAST);
        frame_end = slot_end && (row_q == 2'd3);
        slot_d    = slot_end ? '0 : slot_q + SLOT_W'(1);
        row_d     = slot_end ? row_q + 2'd1 : row_q;

        col_low    = ~col_sync;
        row_single = (col_low != 4'd0) && ((col_low & (col_low - 4'd1)) == 4'd0);
        row_multi  = (col_low != 4'd0) && !row_single;
        col_idx    = 2'd0;
        for (int c = 3; c >= 0; c--) begin
            if (col_low[c]) col_idx = 2'(c);
        end

        hit_now   = acc_hit_q || row_single;
        multi_now = acc_multi_q || row_multi || (acc_hit_q && row_single);
        code_now  = row_single ? key_code(row_q, col_idx) : acc_code_q;

        if (multi_now)    frame_res = FRAME_MULTI;
        else if (hit_now) frame_res = FRAME_SINGLE;
        else              frame_res = FRAME_NONE;

        acc_hit_d   = acc_hit_q;
        acc_multi_d = acc_multi_q;
        acc_code_d  = acc_code_q;
        if (frame_end) begin
            acc_hit_d   = 1'b0;
            acc_multi_d = 1'b0;
            acc_code_d  = 4'd0;
        end else if (slot_end) begin
            acc_hit_d   = hit_now;
            acc_multi_d = multi_now;
            acc_code_d  = code_now;
        end
    end

    always_comb begin
        state_d = state_q;
        cand_d  = cand_q;
        cnt_d   = cnt_q;
        value_d = value_q;
        key_d   = 1'b0;
        accept  = 1'b0;
        cnt_inc = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_W'(1);
`ifdef KEY_REPEAT_EN
        rep_cnt_d     = rep_cnt_q;
        rep_started_d = rep_started_q;
        rep_inc       = (rep_cnt_q == '1) ? rep_cnt_q : rep_cnt_q + REP_W'(1);
`endif

        if (frame_end) begin
            case (state_q)
                ST_IDLE: begin
                    if (frame_res == FRAME_SINGLE) begin
                        cand_d  = code_now;
                        cnt_d   = CNT_ONE;
                        state_d = ST_DEBOUNCE;
                        accept  = (CNT_ONE >= DEB_TARGET);
                    end
                end
                ST_DEBOUNCE: begin
                    if (frame_res != FRAME_SINGLE) begin
                        state_d = ST_IDLE;
                    end else if (code_now == cand_q) begin
                        cnt_d  = cnt_inc;
                        accept = (cnt_inc >= DEB_TARGET);
                    end else begin
                        cand_d = code_now;
                        cnt_d  = CNT_ONE;
                        accept = (CNT_ONE >= DEB_TARGET);
                    end
                end
                ST_HELD: begin
                    if (frame_res == FRAME_NONE) begin
                        cnt_d   = CNT_ONE;
                        state_d = (CNT_ONE >= DEB_TARGET) ? ST_IDLE : ST_RELEASE;
                    end
`ifdef KEY_REPEAT_EN
                    else if (frame_res == FRAME_SINGLE && code_now == value_q &&
                             value_q != KEY_ENTER) begin
                        if (rep_inc >= (rep_started_q ? REP_RATE : REP_DELAY)) begin
                            key_d         = 1'b1;
                            rep_cnt_d     = '0;
                            rep_started_d = 1'b1;
                        end else begin
                            rep_cnt_d = rep_inc;
                        end
                    end
`endif
                end
                ST_RELEASE: begin
                    if (frame_res == FRAME_NONE) begin
                        cnt_d = cnt_inc;
                        if (cnt_inc >= DEB_TARGET) state_d = ST_IDLE;
                    end else begin
                        state_d = ST_HELD;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end

        if (accept) begin
            value_d = cand_d;
            key_d   = 1'b1;
            state_d = ST_HELD;
        end

`ifdef KEY_REPEAT_EN
        // Repeat timing restarts whenever HELD is entered or left.
        if (!(state_q == ST_HELD && state_d == ST_HELD)) begin
            rep_cnt_d     = '0;
            rep_started_d = 1'b0;
        end
`endif
    end

    always_ff @(posedge IN_clk) begin
        if (IN_reset) begin
            slot_q      <= '0;
            row_q       <= 2'd0;
            acc_hit_q   <= 1'b0;
            acc_multi_q <= 1'b0;
            acc_code_q  <= 4'd0;
            state_q     <= ST_IDLE;
            cand_q      <= 4'd0;
            cnt_q       <= '0;
            value_q     <= 4'd0;
            key_q       <= 1'b0;
        end else begin
            slot_q      <= slot_d;
            row_q       <= row_d;
            acc_hit_q   <= acc_hit_d;
            acc_multi_q <= acc_multi_d;
            acc_code_q  <= acc_code_d;
            state_q     <= state_d;
            cand_q      <= cand_d;
            cnt_q       <= cnt_d;
            value_q     <= value_d;
            key_q       <= key_d;
        end
    end

`ifdef KEY_REPEAT_EN
    always_ff @(posedge IN_clk) begin
        if (IN_reset) begin
            rep_cnt_q     <= '0;
            rep_started_q <= 1'b0;
        end else begin
            rep_cnt_q     <= rep_cnt_d;
            rep_started_q <= rep_started_d;
        end
    end
`endif

    assign OUT_row   = ~(4'b0001 << row_q);
    assign OUT_value = value_q;
    assign OUT_key   = key_q;
    assign OUT_state = state_q;

endmodule

// File: tb/tb_key_scan.sv
// Directed bench for key_scan (SCAN_DIV=4, DEBOUNCE_FRAMES=3, repeat 4/2);
// the repeat scenario expectations follow KEY_REPEAT_EN.
module tb_key_scan;
  import key_pkg::*;

  localparam int SCAN_DIV = 4;
  localparam int DEB      = 3;
  localparam int FRAME    = 4 * SCAN_DIV;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] col;
  logic [3:0] row;
  logic [3:0] value;
  logic       key;
  key_state_e state;

  logic [15:0] pressed = 16'h0000;

  int tests = 0;
  int fails = 0;
  logic [3:0] exp_q[$];
  int cyc = 0;
  int strobe_cyc = -1;
  int strobes = 0;
  logic rst_edge = 1'b1;
  logic mon_en = 1'b0;
  logic [3:0] last_val = 4'd0;

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc      <= cyc + 1;
    rst_edge <= rst;
  end

  // Keypad model: a pressed key shorts its column to the driven (low) row.
  always_comb begin
    col = 4'hF;
    for (int r = 0; r < 4; r++) begin
      if (!row[r]) col = col & ~pressed[r*4 +: 4];
    end
  end

  key_scan #(
    .SCAN_DIV           (SCAN_DIV),
    .DEBOUNCE_FRAMES    (DEB),
    .REPEAT_DELAY_FRAMES(4),
    .REPEAT_RATE_FRAMES (2)
  ) u_dut (
    .IN_clk   (clk),
    .IN_reset (rst),
    .IN_col   (col),
    .OUT_row  (row),
    .OUT_value(value),
    .OUT_key  (key),
    .OUT_state(state)
  );

  // ---------------- check helpers ----------------
  task automatic check_int(input string name, input int act, input int exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic check_val(input string name, input logic [3:0] act, input logic [3:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- scoreboard monitor ----------------
  always @(negedge clk) begin
    if (mon_en) begin
      if (key === 1'b1) begin
        strobes++;
        strobe_cyc = cyc;
        if (exp_q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_strobe: got value %h with no strobe expected (cycle %0d)", value, cyc);
        end else begin
          check_val("strobe_value", value, exp_q.pop_front());
        end
      end
      tests++;
      if (value !== last_val && key !== 1'b1 && rst_edge !== 1'b1) begin
        fails++;
        $display("FAIL value_hold: value changed %h -> %h without strobe (cycle %0d)", last_val, value, cyc);
      end
      last_val = value;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic frames(input int n);
    repeat (n * FRAME) @(negedge clk);
  endtask

  task automatic press(input logic [15:0] keys, input int n);
    pressed = keys;
    frames(n);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int p;
    int s0;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;

    check_val("reset_row", row, 4'b1110);
    check_val("reset_value", value, 4'd0);
    check_int("reset_key", int'(key), 0);
    check_int("reset_state", int'(state), int'(ST_IDLE));
    last_val = value;
    mon_en   = 1'b1;

    for (int s = 0; s < 4; s++) begin
      check_val("row_scan", row, ~(4'b0001 << s));
      repeat (SCAN_DIV) @(negedge clk);
    end

    // Clean press of r1/c1 -> 5.
    exp_q.push_back(4'h5);
    p = cyc;
    press(16'h0020, 6);
    check_int("clean_latency", strobe_cyc, p + DEB * FRAME);
    check_val("clean_value_held", value, 4'h5);
    press(16'h0000, 2);
    check_int("clean_release_state", int'(state), int'(ST_RELEASE));
    frames(1);
    check_int("clean_idle_state", int'(state), int'(ST_IDLE));

    // Bounce on r0/c3, then stable -> A.
    s0 = strobes;
    for (int i = 0; i < 5; i++) press((i % 2 == 0) ? 16'h0008 : 16'h0000, 1);
    check_int("bounce_no_strobe", strobes, s0);
    exp_q.push_back(4'hA);
    press(16'h0008, 4);
    check_int("bounce_one_strobe", strobes, s0 + 1);
    press(16'h0000, 3);

    // Two columns in r2 -> MULTI, then c0 alone -> 7.
    s0 = strobes;
    press(16'h0300, 10);
    check_int("multi_no_strobe", strobes, s0);
    check_int("multi_state", int'(state), int'(ST_IDLE));
    exp_q.push_back(4'h7);
    p = cyc;
    press(16'h0100, 4);
    check_int("multi_latency", strobe_cyc, p + DEB * FRAME);
    press(16'h0000, 3);

    // Hold 0 (r3/c1), add 1 (r0/c0), then drop 0: 1 is never reported.
    exp_q.push_back(4'h0);
    press(16'h2000, 4);
    s0 = strobes;
    press(16'h2001, 3);
    press(16'h0001, 3);
    check_int("second_key_held", int'(state), int'(ST_HELD));
    check_int("second_key_no_strobe", strobes, s0);
    press(16'h0000, 3);
    check_int("second_key_idle", int'(state), int'(ST_IDLE));
    exp_q.push_back(4'h1);
    press(16'h0001, 4);
    check_int("second_key_then_one", strobes, s0 + 1);
    press(16'h0000, 3);

    // Reset after two matching frames of F (r3/c2).
    s0 = strobes;
    press(16'h4000, 2);
    check_int("rst_mid_debounce", int'(state), int'(ST_DEBOUNCE));
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check_val("rst_mid_row", row, 4'b1110);
    check_val("rst_mid_value", value, 4'd0);
    check_int("rst_mid_state", int'(state), int'(ST_IDLE));
    check_int("rst_mid_no_strobe", strobes, s0);
    exp_q.push_back(4'hF);
    p = cyc;
    frames(4);
    check_int("rst_mid_latency", strobe_cyc, p + DEB * FRAME);
    check_int("rst_mid_one_strobe", strobes, s0 + 1);
    press(16'h0000, 3);

    // Hold 9 (r2/c2) for 12 frames.
    s0 = strobes;
    p  = cyc;
`ifdef KEY_REPEAT_EN
    for (int i = 0; i < 4; i++) exp_q.push_back(4'h9);
    press(16'h0400, 12);
    check_int("repeat_count", strobes, s0 + 4);
    check_int("repeat_last", strobe_cyc, p + 11 * FRAME);
`else
    exp_q.push_back(4'h9);
    press(16'h0400, 12);
    check_int("hold9_count", strobes, s0 + 1);
    check_int("hold9_latency", strobe_cyc, p + DEB * FRAME);
`endif
    press(16'h0000, 3);

    // Hold F for 12 frames: only the accept strobe.
    s0 = strobes;
    exp_q.push_back(4'hF);
    press(16'h4000, 12);
    check_int("enter_single", strobes, s0 + 1);
    press(16'h0000, 3);

    check_int("final_state", int'(state), int'(ST_IDLE));
    check_int("queue_empty", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
